// File: rtl/cas_fsk_player.sv
// cas_fsk_player: plays a tape image from a synchronous byte buffer as CoCo FSK,
// LSB first, bit 0 = one 1200 Hz cycle, bit 1 = one 2400 Hz cycle.
// Optional motor spin-up delay is compiled in with `define CAS_MOTOR_DELAY_EN.
module cas_fsk_player #(
    parameter int ADDR_W          = 16,
    parameter int RD_LAT          = 2,
    parameter int HALF0_TICKS     = 372,
    parameter int HALF1_TICKS     = 186,
    parameter int MOTOR_DLY_TICKS = 0
) (
    input  logic              clk,
    input  logic              RESET_N,
    input  logic              ce,
    input  logic              rewind,
    input  logic              motor,
    input  logic [ADDR_W-1:0] tape_len,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_req,
    input  logic [7:0]        rd_data,
    output logic              dout,
    output logic              busy,
    output logic              eot,
    output logic [ADDR_W-1:0] pos
);

    localparam int HMAX   = (HALF0_TICKS > HALF1_TICKS) ? HALF0_TICKS : HALF1_TICKS;
    localparam int TICK_W = $clog2(HMAX + 1);
    localparam logic [TICK_W-1:0] H0_LAST  = TICK_W'(HALF0_TICKS - 1);
    localparam logic [TICK_W-1:0] H1_LAST  = TICK_W'(HALF1_TICKS - 1);
    localparam logic [2:0]        LAT_LAST = 3'(RD_LAT);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_HI    = 3'd2,
        ST_LO    = 3'd3,
        ST_EOT   = 3'd4
    } state_t;

    state_t              state_r, state_nx;
    logic [TICK_W-1:0]   tick_r, tick_nx;
    logic [2:0]          bit_r, bit_nx;
    logic [2:0]          lat_r, lat_nx;
    logic [7:0]          sh_r, sh_nx;
    logic [ADDR_W-1:0]   pos_r, pos_nx;
    logic [ADDR_W-1:0]   rd_addr_r, rd_addr_nx;
    logic                rd_req_r, rd_req_nx;
    logic                dout_r, busy_r, eot_r;
    logic [ADDR_W:0]     len_ext_s;
    logic [ADDR_W:0]     pos_inc_s;
    logic                at_end_s;
    logic                end_after_s;
    logic                half_done_s;
    logic                run_s;
    logic                spin_s;

    // Last tick index of a half-cycle for the given bit value
    function automatic logic [TICK_W-1:0] half_last(input logic bit_v);
        if (bit_v) begin
            half_last = H1_LAST;
        end else begin
            half_last = H0_LAST;
        end
    endfunction

`ifdef CAS_MOTOR_DELAY_EN
    localparam int DLY_N  = (MOTOR_DLY_TICKS > 0) ? MOTOR_DLY_TICKS : 1;
    localparam int SPIN_W = $clog2(DLY_N + 1);
    localparam logic [SPIN_W-1:0] DLY_LAST = SPIN_W'(DLY_N - 1);
    localparam logic              DLY_ON   = (MOTOR_DLY_TICKS > 0);

    logic              motor_q_r;
    logic              spin_r;
    logic [SPIN_W-1:0] spin_cnt_r;
    logic              rise_s;

    // The rising clk itself already belongs to the spin-up window
    assign rise_s = motor && !motor_q_r && (state_r != ST_EOT) && DLY_ON;
    assign spin_s = spin_r || rise_s;
    assign run_s  = motor && !spin_s;

    // Spin-up counter: restarted by each motor rise, cleared by a motor drop
    always_ff @(posedge clk) begin
        if (!RESET_N) begin
            motor_q_r  <= 1'b0;
            spin_r     <= 1'b0;
            spin_cnt_r <= {SPIN_W{1'b0}};
        end else begin
            motor_q_r <= motor;
            if (!motor) begin
                spin_r     <= 1'b0;
                spin_cnt_r <= {SPIN_W{1'b0}};
            end else if (spin_s && ce) begin
                if (spin_cnt_r == DLY_LAST) begin
                    spin_r     <= 1'b0;
                    spin_cnt_r <= {SPIN_W{1'b0}};
                end else begin
                    spin_r     <= 1'b1;
                    spin_cnt_r <= spin_cnt_r + SPIN_W'(1);
                end
            end else begin
                spin_r <= spin_s;
            end
        end
    end
`else
    logic [31:0] dly_unused_s;

    assign dly_unused_s = MOTOR_DLY_TICKS;
    assign spin_s       = 1'b0;
    assign run_s        = motor;
`endif

    // tape_len of zero stands for the whole buffer, hence the extra bit
    assign len_ext_s   = (tape_len == {ADDR_W{1'b0}}) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, tape_len};
    assign pos_inc_s   = {1'b0, pos_r} + {{ADDR_W{1'b0}}, 1'b1};
    assign at_end_s    = ({1'b0, pos_r} >= len_ext_s);
    assign end_after_s = (pos_inc_s >= len_ext_s);
    assign half_done_s = run_s && ce && (tick_r == half_last(sh_r[0]));

    // Next-state and datapath update
    always_comb begin
        state_nx   = state_r;
        tick_nx    = tick_r;
        bit_nx     = bit_r;
        lat_nx     = lat_r;
        sh_nx      = sh_r;
        pos_nx     = pos_r;
        rd_addr_nx = rd_addr_r;
        rd_req_nx  = 1'b0;
        if (rewind) begin
            state_nx   = ST_IDLE;
            tick_nx    = {TICK_W{1'b0}};
            bit_nx     = 3'd0;
            lat_nx     = 3'd0;
            pos_nx     = {ADDR_W{1'b0}};
            rd_addr_nx = {ADDR_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (run_s && at_end_s) begin
                        state_nx = ST_EOT;
                    end else if (run_s) begin
                        state_nx   = ST_FETCH;
                        rd_req_nx  = 1'b1;
                        rd_addr_nx = pos_r;
                        lat_nx     = 3'd0;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
                // Latency count runs on clk alone so a motor drop cannot lose data
                ST_FETCH: begin
                    if (lat_r == LAT_LAST) begin
                        sh_nx    = rd_data;
                        bit_nx   = 3'd0;
                        tick_nx  = {TICK_W{1'b0}};
                        lat_nx   = 3'd0;
                        state_nx = ST_HI;
                    end else begin
                        lat_nx = lat_r + 3'd1;
                    end
                end
                ST_HI: begin
                    if (half_done_s) begin
                        tick_nx  = {TICK_W{1'b0}};
                        state_nx = ST_LO;
                    end else if (run_s && ce) begin
                        tick_nx = tick_r + TICK_W'(1);
                    end else begin
                        tick_nx = tick_r;
                    end
                end
                ST_LO: begin
                    if (half_done_s) begin
                        tick_nx = {TICK_W{1'b0}};
                        if (bit_r != 3'd7) begin
                            bit_nx   = bit_r + 3'd1;
                            sh_nx    = {1'b0, sh_r[7:1]};
                            state_nx = ST_HI;
                        end else begin
                            pos_nx = pos_inc_s[ADDR_W-1:0];
                            if (end_after_s) begin
                                state_nx = ST_EOT;
                            end else begin
                                state_nx   = ST_FETCH;
                                rd_req_nx  = 1'b1;
                                rd_addr_nx = pos_inc_s[ADDR_W-1:0];
                                lat_nx     = 3'd0;
                            end
                        end
                    end else if (run_s && ce) begin
                        tick_nx = tick_r + TICK_W'(1);
                    end else begin
                        tick_nx = tick_r;
                    end
                end
                ST_EOT: begin
                    state_nx = ST_EOT;
                end
                default: begin
                    state_nx = ST_IDLE;
                end
            endcase
        end
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!RESET_N) begin
            state_r   <= ST_IDLE;
            tick_r    <= {TICK_W{1'b0}};
            bit_r     <= 3'd0;
            lat_r     <= 3'd0;
            sh_r      <= 8'd0;
            pos_r     <= {ADDR_W{1'b0}};
            rd_addr_r <= {ADDR_W{1'b0}};
            rd_req_r  <= 1'b0;
            dout_r    <= 1'b0;
            busy_r    <= 1'b0;
            eot_r     <= 1'b0;
        end else begin
            state_r   <= state_nx;
            tick_r    <= tick_nx;
            bit_r     <= bit_nx;
            lat_r     <= lat_nx;
            sh_r      <= sh_nx;
            pos_r     <= pos_nx;
            rd_addr_r <= rd_addr_nx;
            rd_req_r  <= rd_req_nx;
            dout_r    <= (state_nx == ST_HI) && !spin_s;
            busy_r    <= (state_nx == ST_FETCH) || (state_nx == ST_HI) || (state_nx == ST_LO);
            eot_r     <= (state_nx == ST_EOT);
        end
    end

    assign rd_addr = rd_addr_r;
    assign rd_req  = rd_req_r;
    assign dout    = dout_r;
    assign busy    = busy_r;
    assign eot     = eot_r;
    assign pos     = pos_r;

endmodule

// File: tb/tb_cas_fsk_player.sv
// Self-checking bench for cas_fsk_player: vector table of whole tapes, hand-written
// corner sequences, and randomized playback against a segment-queue reference model.
module tb_cas_fsk_player;

    localparam int AW  = 4;
    localparam int LAT = 2;
    localparam int H0  = 4;
    localparam int H1  = 2;
`ifdef CAS_MOTOR_DELAY_EN
    localparam int SPIN = 10;
`else
    localparam int SPIN = 0;
`endif

    logic          clk = 1'b0;
    logic          RESET_N, ce, rewind, motor;
    logic [AW-1:0] tape_len, rd_addr, pos;
    logic          rd_req, dout, busy, eot;
    logic [7:0]    rd_data;
    logic [7:0]    mem [16];
    logic [7:0]    pipe0 = 8'h00;
    logic [7:0]    pipe1 = 8'h00;
    int            n_cmp = 0;
    int            n_bad = 0;

    typedef struct {
        logic [7:0]    fill;
        logic [7:0]    b0, b1, b2;
        logic [AW-1:0] len;
        int            exp_cyc;
        int            exp_req;
        logic [AW-1:0] exp_pos;
    } vec_t;

    typedef struct {
        int kind;   // 0 fetch, 1 high half, 2 low half
        int len;    // clks for fetch, ce ticks for halves
        int addr;
    } seg_t;

    always #5 clk = ~clk;

    cas_fsk_player #(
        .ADDR_W(AW), .RD_LAT(LAT), .HALF0_TICKS(H0), .HALF1_TICKS(H1), .MOTOR_DLY_TICKS(10)
    ) dut (
        .clk(clk), .RESET_N(RESET_N), .ce(ce), .rewind(rewind), .motor(motor),
        .tape_len(tape_len), .rd_addr(rd_addr), .rd_req(rd_req), .rd_data(rd_data),
        .dout(dout), .busy(busy), .eot(eot), .pos(pos)
    );

    // Buffer model: data appears LAT clks after the strobe, junk otherwise
    always @(posedge clk) begin
        pipe0 <= rd_req ? mem[rd_addr] : 8'($urandom);
        pipe1 <= pipe0;
    end
    assign rd_data = pipe1;

    function automatic logic [11:0] outv();
        return {rd_req, rd_addr, dout, busy, eot, pos};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic start_tape();
        motor  = 1'b0;
        ce     = 1'b1;
        rewind = 1'b1;
        @(negedge clk);
        rewind = 1'b0;
        @(negedge clk);
    endtask

    // Plays to end of tape with ce every clk; optional 50-clk motor pause at a busy-cycle index
    task automatic play(input int pause_at, output int cyc, output int reqs, output logic got_eot);
        cyc = 0; reqs = 0; got_eot = 1'b0;
        motor = 1'b1; ce = 1'b1;
        for (int c = 0; c < 4000 && !got_eot; c++) begin
            @(negedge clk);
            if (eot) begin
                got_eot = 1'b1;
            end else begin
                if (busy) cyc++;
                if (rd_req) reqs++;
                if (busy && cyc == pause_at) begin
                    check("pause_entry_dout", dout, 1);
                    motor = 1'b0;
                    for (int k = 0; k < 50; k++) begin
                        @(negedge clk);
                        check("pause_dout_held", {dout, busy}, 2'b11);
                        if (busy) cyc++;
                        if (rd_req) reqs++;
                    end
                    motor = 1'b1;
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (rd_req) reqs++;
        end
    endtask

    // Random tape, random ce and motor gaps, checked cycle by cycle against a segment queue
    task automatic run_random(input int nbytes);
        seg_t          q[$];
        seg_t          s;
        int            done;
        int            cyc;
        int            h;
        logic [11:0]   exp_v;
        for (int p = 0; p < 16; p++) mem[p] = 8'($urandom);
        tape_len = AW'(nbytes);
        for (int p = 0; p < nbytes; p++) begin
            q.push_back('{0, LAT + 1, p});
            for (int b = 0; b < 8; b++) begin
                h = mem[p][b] ? H1 : H0;
                q.push_back('{1, h, p});
                q.push_back('{2, h, p});
            end
        end
        start_tape();
        motor = 1'b1; ce = 1'b1;
        repeat (SPIN) @(negedge clk);
        done = 0; cyc = 0;
        while (q.size() > 0 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            s = q[0];
            exp_v = {(s.kind == 0) && (done == 0), AW'(s.addr), s.kind == 1, 1'b1, 1'b0, AW'(s.addr)};
            check("rand_cycle", outv(), exp_v);
            ce    = ($urandom_range(0, 3) != 0);
            motor = (SPIN == 0) ? ($urandom_range(0, 7) != 0) : 1'b1;
            if (s.kind == 0 || (ce && motor)) done++;
            if (done == s.len) begin
                void'(q.pop_front());
                done = 0;
            end
        end
        check("rand_budget", q.size(), 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rand_eot", outv(), {1'b0, AW'(nbytes - 1), 1'b0, 1'b0, 1'b1, AW'(nbytes)});
        end
    endtask

    initial begin
        vec_t tbl [5];
        int   cyc, reqs, n;
        logic ge;

        tbl[0] = '{8'h00, 8'h01, 8'h00, 8'h00, 4'd1,  63,  1, 4'd1};
        tbl[1] = '{8'h00, 8'hFF, 8'h00, 8'h00, 4'd2, 102,  2, 4'd2};
        tbl[2] = '{8'h00, 8'h00, 8'hFF, 8'h0F, 4'd3, 153,  3, 4'd3};
        tbl[3] = '{8'h00, 8'h01, 8'h80, 8'h00, 4'd5, 327,  5, 4'd5};
        tbl[4] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 4'd0, 560, 16, 4'd0};

        RESET_N = 1'b0; ce = 1'b0; rewind = 1'b0; motor = 1'b0; tape_len = 4'd0;
        for (int a = 0; a < 16; a++) mem[a] = 8'h00;
        repeat (2) @(negedge clk);
        check("reset_outputs", outv(), 12'h000);
        RESET_N = 1'b1;
        @(negedge clk);
        check("idle_no_motor", outv(), 12'h000);

        // Whole-tape vectors
        for (int i = 0; i < 5; i++) begin
            for (int a = 0; a < 16; a++) mem[a] = tbl[i].fill;
            mem[0] = tbl[i].b0; mem[1] = tbl[i].b1; mem[2] = tbl[i].b2;
            tape_len = tbl[i].len;
            start_tape();
            play(-1, cyc, reqs, ge);
            check("tbl_eot", ge, 1);
            check("tbl_cycles", cyc, tbl[i].exp_cyc);
            check("tbl_reqs", reqs, tbl[i].exp_req);
            check("tbl_pos", pos, tbl[i].exp_pos);
            check("tbl_eot_levels", {dout, busy, eot}, 3'b001);
        end

        // Motor pause of 50 clks inside the high half of bit 1
        for (int a = 0; a < 16; a++) mem[a] = 8'h00;
        mem[0] = 8'h01; tape_len = 4'd1;
        start_tape();
        play(9, cyc, reqs, ge);
        check("pause_eot", ge, 1);
        check("pause_cycles", cyc, 63 + 50 + SPIN);

        // First high half starts RD_LAT+1 clks after the motor is seen (plus spin-up)
        start_tape();
        motor = 1'b1; n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dout && n < 100);
        check("hi_start_delay", n, SPIN + LAT + 2);

        // Rewind during byte 1 of 3, then rewind out of EOT
        mem[0] = 8'h00; mem[1] = 8'h00; mem[2] = 8'h00; tape_len = 4'd3;
        start_tape();
        motor = 1'b1;
        for (int k = 0; k < 500 && pos != 4'd1; k++) @(negedge clk);
        check("rew_reach_byte1", pos, 1);
        repeat (5) @(negedge clk);
        rewind = 1'b1;
        @(negedge clk);
        check("rew_state", {rd_req, dout, busy, eot, pos}, 8'h00);
        @(negedge clk);
        check("rew_held_idle", {rd_req, busy, pos}, 6'h00);
        rewind = 1'b0;
        @(negedge clk);
        check("rew_refetch", {rd_req, rd_addr}, {1'b1, 4'd0});
        for (int k = 0; k < 1000 && !eot; k++) @(negedge clk);
        check("rew_play_eot", {eot, pos}, {1'b1, 4'd3});
        motor = 1'b0; rewind = 1'b1;
        @(negedge clk);
        rewind = 1'b0;
        check("rew_clears_eot", {eot, pos}, {1'b0, 4'd0});

        // Reset while fetching byte 1: stale data ignored, restart at address 0
        mem[0] = 8'h01; mem[1] = 8'h00; tape_len = 4'd2;
        start_tape();
        motor = 1'b1;
        for (int k = 0; k < 500 && !(rd_req && rd_addr == 4'd1); k++) @(negedge clk);
        check("rst_reach_fetch1", {rd_req, rd_addr}, {1'b1, 4'd1});
        RESET_N = 1'b0;
        @(negedge clk);
        check("rst_outputs", outv(), 12'h000);
        RESET_N = 1'b1;
        for (int k = 0; k < 40 && !rd_req; k++) @(negedge clk);
        check("rst_first_read", {rd_req, rd_addr}, {1'b1, 4'd0});
        for (int k = 0; k < 40 && !dout; k++) @(negedge clk);
        n = 0;
        while (dout && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("rst_first_half", n, H1);

        // Randomized playback
        for (int r = 0; r < 8; r++) run_random($urandom_range(1, 5));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
